// File: rtl/cla_sched_pkg.sv
// rtl/cla_sched_pkg.sv - shared constants and FSM encoding for the CLA add scheduler
package cla_sched_pkg;

    // Width of one adder pass.
    localparam int WORD_W = 32;

    // Scheduler FSM encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/carry_lookahead_adder_32bits.sv
// rtl/carry_lookahead_adder_32bits.sv - 32-bit two-level carry lookahead adder
// Ports:
//   in0, in1 : operands
//   carry_in : incoming carry
//   sum      : in0 + in1 + carry_in (low 32 bits)
//   pg       : group propagate of all 32 bits
//   gg       : group generate of all 32 bits (carry out = gg | pg & carry_in)
module carry_lookahead_adder_32bits (
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic        carry_in,
    output logic [31:0] sum,
    output logic        pg,
    output logic        gg
);

    always_comb begin
        logic [31:0] g;
        logic [31:0] p;
        logic [31:0] c;
        logic [7:0]  grp_g;
        logic [7:0]  grp_p;
        logic [8:0]  grp_c;
        logic        gg_acc;

        g = in0 & in1;
        p = in0 ^ in1;

        // Nibble-level generate/propagate.
        for (int i = 0; i < 8; i++) begin
            grp_g[i] = g[4*i+3]
                     | (p[4*i+3] & g[4*i+2])
                     | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                     | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
            grp_p[i] = &p[4*i +: 4];
        end

        // Carries into each nibble from the group terms.
        grp_c[0] = carry_in;
        for (int i = 0; i < 8; i++) begin
            grp_c[i+1] = grp_g[i] | (grp_p[i] & grp_c[i]);
        end

        // Bit carries inside each nibble.
        for (int i = 0; i < 8; i++) begin
            c[4*i] = grp_c[i];
            for (int j = 1; j < 4; j++) begin
                c[4*i+j] = g[4*i+j-1] | (p[4*i+j-1] & c[4*i+j-1]);
            end
        end

        sum = p ^ c;
        pg  = &grp_p;

        // Carry-in independent generate of the whole word.
        gg_acc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            gg_acc = grp_g[i] | (grp_p[i] & gg_acc);
        end
        gg = gg_acc;
    end

endmodule

// File: rtl/cla_rr_arbiter_2.sv
// rtl/cla_rr_arbiter_2.sv - two-input round-robin grant
// Ports:
//   valid0, valid1 : request lines
//   rr_ptr         : requester that wins when both are valid
//   grant          : one-hot grant (all-zero when nothing is valid)
module cla_rr_arbiter_2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       rr_ptr,
    output logic [1:0] grant
);

    // A lone requester always wins; on contention rr_ptr decides.
    assign grant[0] = valid0 & (~valid1 | ~rr_ptr);
    assign grant[1] = valid1 & (~valid0 |  rr_ptr);

endmodule

// File: rtl/cla_add_scheduler.sv
// rtl/cla_add_scheduler.sv - shares one 32-bit CLA between two multi-word add requesters
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   req0_valid/ready/a/b/cin       : requester 0 (W-bit operands, initial carry)
//   req1_valid/ready/a/b/cin       : requester 1
//   rsp_valid/ready                : response handshake
//   rsp_id                         : requester that owns the response
//   rsp_sum, rsp_cout              : A+B+cin modulo 2^W and carry out of bit W-1
module cla_add_scheduler
    import cla_sched_pkg::*;
#(
    parameter  int NUM_WORDS = 2,
    localparam int W         = WORD_W * NUM_WORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_cin,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_cin,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_sum,
    output logic         rsp_cout
);

    localparam int               IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t             state_q;
    state_t             state_d;
    logic               rr_ptr_q;
    logic [IDX_W-1:0]   word_idx_q;
    logic               carry_q;
    logic               id_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       sum_q;

    logic [1:0]         grant;
    logic               accept;
    logic [WORD_W-1:0]  add_in0;
    logic [WORD_W-1:0]  add_in1;
    logic [WORD_W-1:0]  add_sum;
    logic               add_pg;
    logic               add_gg;
    logic               carry_next;

    cla_rr_arbiter_2 u_arb (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .rr_ptr (rr_ptr_q),
        .grant  (grant)
    );

    assign add_in0 = a_q[int'(word_idx_q) * WORD_W +: WORD_W];
    assign add_in1 = b_q[int'(word_idx_q) * WORD_W +: WORD_W];

    carry_lookahead_adder_32bits u_adder (
        .in0      (add_in0),
        .in1      (add_in1),
        .carry_in (carry_q),
        .sum      (add_sum),
        .pg       (add_pg),
        .gg       (add_gg)
    );

    assign carry_next = add_gg | (add_pg & carry_q);

    // Grant is only meaningful while idle; the single-entry datapath blocks otherwise.
    assign req0_ready = (state_q == IDLE) & grant[0];
    assign req1_ready = (state_q == IDLE) & grant[1];
    assign accept     = (state_q == IDLE) & (|grant);

    assign rsp_valid  = (state_q == DONE);
    assign rsp_id     = id_q;
    assign rsp_sum    = sum_q;
    assign rsp_cout   = carry_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)                   state_d = RUN;
            RUN:     if (word_idx_q == LAST_IDX)   state_d = DONE;
            DONE:    if (rsp_ready)                state_d = IDLE;
            default:                               state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 1'b0;
            word_idx_q <= '0;
            carry_q    <= 1'b0;
            id_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q        <= grant[1] ? req1_a   : req0_a;
                        b_q        <= grant[1] ? req1_b   : req0_b;
                        carry_q    <= grant[1] ? req1_cin : req0_cin;
                        id_q       <= grant[1];
                        word_idx_q <= '0;
                    end
                end
                RUN: begin
                    sum_q[int'(word_idx_q) * WORD_W +: WORD_W] <= add_sum;
                    carry_q <= carry_next;
                    if (word_idx_q != LAST_IDX) begin
                        word_idx_q <= word_idx_q + 1'b1;
                    end
                end
                DONE: begin
                    // Hand priority to the other requester after each completion.
                    if (rsp_ready) begin
                        rr_ptr_q <= ~id_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cla_add_scheduler.md
Name: cla_add_scheduler

Overview:
- Shares one `carry_lookahead_adder_32bits` instance between two requesters.
- Each request is a multi-word add of NUM_WORDS x 32 bits, executed least-significant word first, one word per cycle, with the carry chained between passes.
- Round-robin arbitration; valid/ready on each request port and on the single response port.
- Sits between integer/FP mantissa producers and the shared adder datapath.

Parameters:
- NUM_WORDS, 2, number of 32-bit passes per request (1..8); operand width W = 32*NUM_WORDS.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_a  in  W  operand A.
- req0_b  in  W  operand B.
- req0_cin  in  1  initial carry.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  1  requester that owns the result (0/1).
- rsp_sum  out  W  A+B+cin modulo 2^W.
- rsp_cout  out  1  carry out of bit W-1.

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset (rst=1 at an edge) forces IDLE, rr_ptr=0, word_idx=0, carry=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0.
- req*_ready is combinational. It is high only in IDLE, only for the granted requester, and never for both requesters in the same cycle.
- Grant in IDLE:
  - Only one valid: grant it.
  - Both valid: grant the requester equal to rr_ptr.
  - None valid: stay in IDLE.
- Acceptance (IDLE, valid & ready at edge):
  - Latch A, B, id.
  - carry <= cin; word_idx <= 0.
  - Go to RUN.
- RUN, each cycle:
  - Adder in0 = A word[word_idx], in1 = B word[word_idx], carry_in = carry.
  - At the edge, result word[word_idx] <= adder sum and carry <= GG | (PG & carry).
  - If word_idx == NUM_WORDS-1, go to DONE; otherwise increment word_idx.
- DONE:
  - rsp_valid=1; rsp_sum, rsp_cout (= final carry) and rsp_id are stable while held.
  - On rsp_valid & rsp_ready at an edge: go to IDLE and set rr_ptr <= ~rsp_id.
- Latency: accept at edge T, then rsp_valid high in the cycle after edge T+NUM_WORDS. The earliest response is NUM_WORDS+1 cycles after acceptance.
- Throughput: one op per NUM_WORDS+2 cycles when rsp_ready is held high. No new request is accepted while RUN or DONE (single-entry, no buffering).
- Backpressure: rsp_ready low holds DONE indefinitely. Requesters see ready=0 the whole time.
- Requester dropping valid before acceptance is legal; nothing is latched.
- Operands changing after acceptance have no effect (latched copy is used).
- Reset mid-RUN or mid-DONE: the operation is discarded, no response is produced, and outputs return to reset values the next cycle.
- Wrap-around: sum is modulo 2^W and the overflow is reported only via rsp_cout.
- NUM_WORDS=1 degenerates to a single pass; the FSM is unchanged.

Decomposition:
- Shared package (cla_sched_pkg) holds:
  - The FSM state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - The 32-bit word-width constant.
- One sub-module: cla_rr_arbiter_2, a two-input round-robin grant taking valid0, valid1 and rr_ptr and returning a one-hot grant.
- The existing `carry_lookahead_adder_32bits` is instantiated directly.

Test Plan:
- Single request, NUM_WORDS=2: req0 A=64'h0000_0000_FFFF_FFFF, B=64'h1, cin=0 -> rsp_sum=64'h0000_0001_0000_0000, rsp_cout=0, rsp_id=0, rsp_valid exactly 3 cycles after acceptance.
- Full overflow: A=64'hFFFF_FFFF_FFFF_FFFF, B=0, cin=1 -> rsp_sum=0 and rsp_cout=1.
- Contention:
  - Both valid from reset with A=5,B=7 (req0) and A=10,B=20 (req1).
  - First grant goes to req0 (sum 12, id 0), second to req1 (sum 30, id 1).
  - Repeat with both valid again -> req0 granted third, confirming rr_ptr alternates.
- Backpressure: hold rsp_ready=0 for 10 cycles in DONE -> rsp_valid and rsp_sum stay stable, req0_ready and req1_ready stay 0; release -> IDLE, next request accepted the following cycle.
- Reset mid-RUN: assert rst during word_idx=0 -> next cycle FSM is IDLE, rsp_valid=0, no response ever issued for the aborted op.
- Randomised sweep: 1000 random A, B, cin at each NUM_WORDS in {1,2,4}, with random valid and rsp_ready patterns -> every response equals the reference A+B+cin (sum and cout), id matches the issuer, and no request is lost or duplicated.
